// File: rtl/mem_wbuf.sv
// mem_wbuf: posted-write FIFO between a CPU and memory, with read priority and read-after-write forwarding
module mem_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic          we,
    output logic [DW-1:0] rdata,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] buf_addr [DEPTH];
    logic [DW-1:0] buf_data [DEPTH];
    logic [PW-1:0] head, tail, idx;
    logic [PW:0]   count;
    logic          hit, hit_q, rd, push, drain;
    logic [DW-1:0] fwd, fwd_q;

    assign rd        = re & ~we;
    assign stall     = count == (PW+1)'(DEPTH);
    assign empty     = count == '0;
    assign push      = we & ~stall;
    assign drain     = ~re & ~empty;
    assign mem_re    = rd;
    assign mem_we    = drain;
    assign mem_addr  = rd ? addr : buf_addr[head];
    assign mem_wdata = buf_data[head];
    assign rdata     = hit_q ? fwd_q : mem_rdata;

    // scan oldest to newest so the newest matching entry wins
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((PW+1)'(i) < count && buf_addr[idx] == addr) begin
                hit = 1'b1;
                fwd = buf_data[idx];
            end
        end
    end

    // entry storage is written on accepted pushes only and needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= addr;
            buf_data[tail] <= wdata;
        end
    end

    // pointers, occupancy and forwarding registers; reset discards pending writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            hit_q <= 1'b0;
            fwd_q <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(drain);
            hit_q <= rd & hit;
            fwd_q <= fwd;
        end
    end
endmodule

// File: tb/tb_mem_wbuf.sv
// tb_mem_wbuf: scoreboard bench for the posted-write buffer against a simple memory model
module tb_mem_wbuf;
    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = '0, wdata = '0, rdata, mem_addr, mem_wdata, mem_rdata;
    logic        re = 1'b0, we = 1'b0, stall, empty, mem_re, mem_we;

    logic [15:0] mem_arr [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    ent_t        wq [$];
    logic [15:0] rq [$];
    bit          have_rd = 0;
    int          total = 0, bad = 0;

    mem_wbuf #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .re(re), .we(we),
        .rdata(rdata), .stall(stall), .empty(empty), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // memory environment: one-cycle read latency
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_wdata === 16'hx ? 16'h0 : mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 16'h0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // one CPU cycle: drive, check combinational/registered outputs, advance the model
    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        ent_t        e;
        logic [15:0] exp;
        bit          full, dr;
        re = r; we = w; addr = a; wdata = d;
        #1;
        full = wq.size() == DEPTH;
        dr   = !r && wq.size() > 0;
        chk("stall", stall, full);
        chk("empty", empty, wq.size() == 0);
        if (have_rd) begin
            chk("rdata", rdata, rq.pop_front());
            have_rd = 0;
        end
        chk("mem_re", mem_re, r && !w);
        chk("mem_we", mem_we, dr);
        if (r && !w) begin
            chk("rd_addr", mem_addr, a);
            exp = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
            foreach (wq[i]) if (wq[i].a == a) exp = wq[i].d;
            rq.push_back(exp);
            have_rd = 1;
        end
        if (dr) begin
            e = wq.pop_front();
            chk("wr_addr", mem_addr, e.a);
            chk("wr_data", mem_wdata, e.d);
            ref_mem[e.a] = e.d;
        end
        if (w && !full) wq.push_back('{a: a, d: d});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        mem_arr[16'h0030] = 16'hCAFE; ref_mem[16'h0030] = 16'hCAFE;
        mem_arr[16'h0020] = 16'h5555; ref_mem[16'h0020] = 16'h5555;
        repeat (2) @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_stall", stall, 0);
        chk("rst_mem_we", mem_we, 0);
        rst = 1'b1;
        // single write then drain
        step(0, 1, 16'h0010, 16'hBEEF);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        // fill with reads blocking the drain, then retry the stalled write
        for (int i = 0; i < 5; i++) step(1, 1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
        step(1, 1, 16'h0104, 16'hA004);
        step(0, 1, 16'h0104, 16'hA004);
        step(0, 1, 16'h0104, 16'hA004);
        repeat (DEPTH + 1) step(0, 0, 0, 0);
        // forwarding picks the newest entry; miss reads go to memory
        step(1, 1, 16'h0020, 16'h1111);
        step(1, 1, 16'h0020, 16'h2222);
        step(1, 0, 16'h0020, 0);
        step(1, 0, 16'h0030, 0);
        step(1, 0, 16'h0020, 0);
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 16'h0020, 0);
        // push and drain together, across several pointer wraps
        step(1, 1, 16'h0200, 16'h0001);
        step(1, 1, 16'h0201, 16'h0002);
        for (int i = 0; i < 2 * DEPTH + 1; i++) step(0, 1, 16'h0210 + 16'(i), 16'h0100 + 16'(i));
        repeat (3) step(0, 0, 0, 0);
        // randomized mix over a small address set
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 16'h0040 + 16'($urandom_range(0, 3)), 16'($urandom));
        repeat (DEPTH + 1) step(0, 0, 0, 0);
        // asynchronous reset with three writes pending
        for (int i = 0; i < 3; i++) step(1, 1, 16'h0300 + 16'(i), 16'hD000 + 16'(i));
        re = 0; we = 0;
        #2 rst = 1'b0;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_stall", stall, 0);
        chk("arst_mem_we", mem_we, 0);
        wq.delete();
        rq.delete();
        have_rd = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (DEPTH + 2) step(0, 0, 0, 0);
        step(1, 0, 16'h0300, 0);
        step(0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_wbuf.md
# mem_wbuf

Posted-write buffer between the `cpu` bus master and `dpi_memory`. CPU writes go into a small FIFO and complete immediately. The FIFO drains to memory in any cycle the CPU is not reading. Reads always get the memory port first, and a read whose address is still waiting in the buffer returns the buffered data. The block asserts `stall` to the CPU's `halt` input when the buffer is full.

## Interface
- `DEPTH`, 4: buffer entries; power of two, ≥2
- `AW`, 16: address width
- `DW`, 16: data width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `addr`  in  AW  CPU address, valid with `re` or `we`
- `wdata`  in  DW  CPU write data
- `re`  in  1  CPU read strobe
- `we`  in  1  CPU write strobe
- `rdata`  out  DW  CPU read data, valid in the cycle after an accepted `re`
- `stall`  out  1  buffer full; connects to CPU `halt`
- `empty`  out  1  no writes pending
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_re`  out  1  memory read strobe
- `mem_we`  out  1  memory write strobe
- `mem_rdata`  in  DW  memory read data, valid one cycle after `mem_re`

## Operation
- **Storage:** circular FIFO of DEPTH {addr, data} entries, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- **Outputs from state:** `stall` = (count == DEPTH); `empty` = (count == 0). Both come from registered count.
- **Write accept:** `we & !stall` pushes {addr, wdata} at tail. A `we` while `stall` is high is ignored; the CPU holds its request and retries.
- **Read:** `re` drives `mem_re=1`, `mem_addr=addr`, `mem_we=0` in the same cycle (combinational pass-through). A read is never stalled.
- **Drain:** in a cycle with `re=0` and count>0, drive `mem_we=1`, `mem_addr/mem_wdata` = head entry, and pop the head.
  - Reads win the port. A continuous read stream starves the drain; this is allowed.
- **Forwarding:** on `re`, compare `addr` against all valid entries.
  - On a hit, register the data from the newest matching entry (closest to tail) and set hit_q=1.
  - Otherwise hit_q=0.
  - `rdata` = hit_q ? fwd_q : `mem_rdata`.
- **re and we together:** treated as a write only. No `mem_re`; hit_q cleared; `rdata` undefined next cycle.
- **Same-cycle push and drain:** when a push and a drain (`we` accepted, `re`=0) occur together, count is unchanged and both pointers advance.
- **Full boundary:** at count=DEPTH, a drain in cycle t lowers `stall` in cycle t+1. A write offered in cycle t is not accepted.
- **Reset (asynchronous, `rst` low):** count, head, tail, hit_q, fwd_q = 0; `stall`=0, `empty`=1, `mem_re`=0, `mem_we`=0.
  - `rdata` follows `mem_rdata`.
  - Buffered writes are discarded, including during a reset mid-drain.
  - Entry storage need not be reset.

## Timing
- Write: accepted at edge t. `empty` falls at t+1. Earliest `mem_we` for that entry is in cycle t+1.
- Drain throughput: one entry per cycle. A full buffer with no reads empties in DEPTH cycles.
- Read latency: `re` in cycle t → `rdata` valid in cycle t+1. This holds for both forwarded and memory reads.
- `rdata` is don't-care in cycles not following an accepted `re`.
- `mem_*` outputs are combinational from `re`/`addr` and from the registered head. There is no added latency on the memory path.
- Write ordering to memory is strictly FIFO, so duplicate addresses land in program order.

## Test plan
- **Reset:**
  - Stimulus: drive `rst` low mid-stream with 3 entries pending.
  - Required: `empty`=1, `stall`=0, `mem_we`=0 immediately (asynchronously). After release, no write from the old entries ever reaches memory.
- **Single write then drain:**
  - Stimulus: `we` with addr 0x0010, data 0xBEEF in cycle 0; idle afterwards.
  - Required: `mem_we`=1 with 0x0010/0xBEEF in cycle 1; `empty`=1 in cycle 2.
- **Fill and stall:**
  - Stimulus: `we` with `re` held high, to addresses 0x0100..0x0104.
  - Required: `stall` rises after the 4th write. The 5th write is ignored until `re` drops. Memory then receives 0x0100..0x0103 in order, followed by 0x0104 once retried.
- **Forwarding:**
  - Stimulus: writes to 0x0020 with 0x1111, then 0x0020 with 0x2222, while reads block the drain; then `re` 0x0020.
  - Required: `rdata`=0x2222 next cycle, and `mem_rdata` is ignored.
- **Miss read:**
  - Stimulus: buffer holds 0x0020; memory holds 0x0030=0xCAFE; `re` 0x0030.
  - Required: `mem_re`=1 with `mem_addr`=0x0030 in the same cycle; `rdata`=0xCAFE next cycle.
- **Push and drain together:**
  - Stimulus: count=2; `we` with `re`=0.
  - Required: count stays 2; head entry written to memory; new entry at tail; pointers wrap correctly after 2×DEPTH writes.
